jtag_seq: RTL and testbench
===========================

JTAG_SEQ -- requirements
Module: jtag_seq

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 Parameter RST_ONES, default 5: number of consecutive tms=1 cycles in any TAP reset sequence; legal range 5..15.
REQ-003 tck  input  1  clock; all state changes on posedge.
REQ-004 reset  input  1  asynchronous active-low reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  block idle and able to accept a command.
REQ-007 cmd_op  input  2  operation: 00 TAP reset, 01 shift IR, 10 shift DR, 11 idle wait.
REQ-008 cmd_len  input  5  bit or cycle count n; 0 encodes 32.
REQ-009 cmd_data  input  32  shift data, LSB shifted first.
REQ-010 tms  output  1  registered TMS to TAP.
REQ-011 tdi  output  1  registered TDI to TAP.
REQ-012 tdo  input  1  serial data from TAP.
REQ-013 rsp_valid  output  1  one-cycle pulse: rsp_data valid.
REQ-014 rsp_data  output  32  captured tdo bits, bit i = i-th bit shifted out.
REQ-015 busy  output  1  equals ~cmd_ready.

Function
REQ-016 States SHALL be INIT, IDLE, PRE, SHIFT, POST, WAIT; a tracked TAP-state model SHALL NOT be exposed.
REQ-017 Handshake: a command SHALL be accepted on a posedge with cmd_valid=1 and cmd_ready=1; cmd_op, cmd_len and cmd_data SHALL be latched at that edge.
REQ-018 cmd_ready SHALL be 1 only in IDLE; cmd_valid outside IDLE SHALL be ignored with no side effects.
REQ-019 Drive sequence: listed values SHALL appear on tms, one per cycle, starting the cycle after acceptance.
REQ-020 Shift DR: PRE tms 1,0,0; SHIFT n cycles with tms=0 except 1 on the last; POST tms 1,0; total n+5 cycles.
REQ-021 Shift IR: PRE tms 1,1,0,0; then as shift DR; total n+6 cycles.
REQ-022 TAP reset (op 00): RST_ONES cycles of tms=1 then one cycle tms=0; cmd_len and cmd_data ignored.
REQ-023 Idle wait (op 11): n cycles of tms=0, tdi=0.
REQ-024 In SHIFT cycle i (0..n-1), tdi SHALL equal latched cmd_data[i]; tdi SHALL be 0 in all other cycles.
REQ-025 At the posedge ending SHIFT cycle i, tdo SHALL be sampled into rsp_data[i]; rsp_data[31:n] SHALL be 0 for n<32.
REQ-026 rsp_data SHALL be held stable from the rsp_valid pulse until the next shift command's acceptance edge.
REQ-027 For shift ops, rsp_valid SHALL pulse high for exactly the first cycle in which cmd_ready is 1 again; reset and wait ops SHALL NOT pulse rsp_valid.
REQ-028 Back-to-back: with cmd_valid held high, the next command SHALL be accepted in that same first IDLE cycle, giving zero gap between sequences.
REQ-029 Every op SHALL end with the TAP in Run_Test_Idle and tms=0 in IDLE.
REQ-030 Counters SHALL be 6 bits wide so that n=32 does not wrap.

Reset
REQ-031 While reset=0: tms=1, tdi=0, cmd_ready=0, busy=1, rsp_valid=0, rsp_data=0, state=INIT.
REQ-032 After reset release, INIT SHALL drive the REQ-022 sequence, then enter IDLE; cmd_ready first rises RST_ONES+1 cycles after release.
REQ-033 Reset asserted mid-command SHALL abort it immediately with no rsp_valid; the command is lost.

Verification
REQ-034 Release reset, RST_ONES=5 -> tms 1,1,1,1,1,0; cmd_ready=1 on cycle 7; a TAP model reaches Run_Test_Idle.
REQ-035 Shift DR, n=8, data 0xA5, TAP loopback tdo=tdi delayed one stage -> tms 1,0,0,0×7,1,1,0; tdi 1,0,1,0,0,1,0,1 in SHIFT; rsp_valid after 13 cycles; rsp_data per model.
REQ-036 Shift IR, cmd_len=0 (32 bits), data 0xFFFFFFFF, tdo=0 -> 38-cycle sequence; rsp_data=0; no counter wrap.
REQ-037 Back-to-back shift IR n=4 then shift DR n=1 -> zero gap; two rsp_valid pulses, 10 and 6 cycles after their respective acceptance edges.
REQ-038 Reset asserted in SHIFT cycle 3 of an n=16 DR shift -> outputs equal REQ-031 values at once; the INIT sequence follows; no rsp_valid.
REQ-039 cmd_valid pulsed during busy, then idle wait n=3 -> pulse ignored; 3 cycles tms=0; no rsp_valid.

Source files
------------

// File: rtl/jtag_seq.sv
// ==== jtag_seq : JTAG TAP command sequencer (reset / shift IR / shift DR / idle wait) -- rev 1.0 ====
`default_nettype none

module jtag_seq #(
  parameter int RST_ONES = 5
) (
  input  logic        tck,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_len,
  input  logic [31:0] cmd_data,
  output logic        tms,
  output logic        tdi,
  input  logic        tdo,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        busy
);

  typedef enum logic [2:0] {INIT, IDLE, PRE, SHIFT, POST, WAIT} state_t;

  localparam logic [5:0] RST_ONES_C = 6'(RST_ONES);

  state_t      state;
  logic [5:0]  cnt;
  logic [5:0]  len_n;
  logic [31:0] sh;
  logic        is_ir;
  logic [5:0]  cmd_n;

  assign cmd_n = (cmd_len == 5'd0) ? 6'd32 : {1'b0, cmd_len};
  assign busy  = ~cmd_ready;

  always_ff @(posedge tck or negedge reset) begin
    if (!reset) begin
      state     <= INIT;
      cnt       <= 6'd0;
      len_n     <= 6'd0;
      sh        <= 32'd0;
      is_ir     <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        // The reset-held cycle (or the acceptance cycle) already counts as the first tms=1.
        INIT: begin
          if (cnt == RST_ONES_C) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            tms       <= 1'b0;
            cnt       <= 6'd0;
          end else begin
            tms <= (cnt + 6'd2 <= RST_ONES_C);
            cnt <= cnt + 6'd1;
          end
        end
        IDLE: begin
          tms <= 1'b0;
          tdi <= 1'b0;
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            len_n     <= cmd_n;
            sh        <= cmd_data;
            cnt       <= 6'd0;
            case (cmd_op)
              2'b00: begin
                state <= INIT;
                tms   <= 1'b1;
              end
              2'b01, 2'b10: begin
                state    <= PRE;
                tms      <= 1'b1;
                is_ir    <= (cmd_op == 2'b01);
                rsp_data <= 32'd0;
              end
              default: begin
                state <= WAIT;
                tms   <= 1'b0;
              end
            endcase
          end
        end
        PRE: begin
          if (is_ir ? (cnt == 6'd3) : (cnt == 6'd2)) begin
            state <= SHIFT;
            cnt   <= 6'd0;
            tms   <= (len_n == 6'd1);
            tdi   <= sh[0];
          end else begin
            tms <= is_ir && (cnt == 6'd0);
            cnt <= cnt + 6'd1;
          end
        end
        SHIFT: begin
          rsp_data[cnt[4:0]] <= tdo;
          if (cnt + 6'd1 < len_n) begin
            cnt <= cnt + 6'd1;
            tms <= (cnt + 6'd2 == len_n);
            tdi <= sh[1];
            sh  <= sh >> 1;
          end else begin
            state <= POST;
            cnt   <= 6'd0;
            tms   <= 1'b1;
            tdi   <= 1'b0;
          end
        end
        POST: begin
          if (cnt == 6'd0) begin
            tms <= 1'b0;
            cnt <= 6'd1;
          end else begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b1;
            tms       <= 1'b0;
            cnt       <= 6'd0;
          end
        end
        WAIT: begin
          if (cnt + 6'd1 < len_n) begin
            cnt <= cnt + 6'd1;
          end else begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            cnt       <= 6'd0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jtag_seq.sv
// ==== tb_jtag_seq : self-checking bench for jtag_seq with a TAP-controller reference model -- rev 1.0 ====
`default_nettype none

module tb_jtag_seq;
  localparam int RST_ONES = 5;
  // TAP next-state tables: 0 TLR,1 RTI,2..8 DR column,9..15 IR column
  localparam int NX0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  localparam int NX1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  logic        tck = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [4:0]  cmd_len = 5'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        tdo = 1'b0;
  logic        cmd_ready, tms, tdi, rsp_valid, busy;
  logic [31:0] rsp_data;

  jtag_seq #(.RST_ONES(RST_ONES)) dut (
    .tck(tck), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data), .tms(tms), .tdi(tdi),
    .tdo(tdo), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 tck = ~tck;

  typedef logic bitq_t[$];
  bitq_t tms_q, sh_tdi, sh_tdo, exp_tms;
  int    tap = 0;
  int    rv_cnt = 0, tdi_bad = 0, tdo_mode = 0;
  logic  lb_q = 1'b0;
  int    errors = 0, checks = 0;

  // Mid-cycle observer: drives tdo, walks the TAP model, records what the TAP shifts.
  always @(negedge tck) begin
    tdo = (tdo_mode == 1) ? lb_q : (tdo_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    if (tap == 4 || tap == 11) begin
      sh_tdi.push_back(tdi);
      sh_tdo.push_back(tdo);
      lb_q = tdi;
    end else if (tdi) begin
      tdi_bad++;
    end
    tms_q.push_back(tms);
    if (rsp_valid) rv_cnt++;
    tap = tms ? NX1[tap] : NX0[tap];
  end

  function automatic logic [63:0] pack64(input bitq_t q);
    logic [63:0] v = 64'd0;
    for (int i = 0; i < q.size() && i < 64; i++) v[i] = q[i];
    return v;
  endfunction

  function automatic int n_of(input logic [4:0] l);
    return (l == 5'd0) ? 32 : int'(l);
  endfunction

  function automatic logic [31:0] low_mask(input int n);
    return 32'((64'h1 << n) - 64'h1);
  endfunction

  task automatic build_exp(input logic [1:0] op, input int n);
    exp_tms.delete();
    case (op)
      2'b00: begin
        repeat (RST_ONES) exp_tms.push_back(1'b1);
        exp_tms.push_back(1'b0);
      end
      2'b01, 2'b10: begin
        exp_tms.push_back(1'b1);
        if (op == 2'b01) exp_tms.push_back(1'b1);
        exp_tms.push_back(1'b0);
        exp_tms.push_back(1'b0);
        for (int i = 0; i < n; i++) exp_tms.push_back(i == n - 1);
        exp_tms.push_back(1'b1);
        exp_tms.push_back(1'b0);
      end
      default: repeat (n) exp_tms.push_back(1'b0);
    endcase
  endtask

  task automatic clr();
    tms_q.delete();
    sh_tdi.delete();
    sh_tdo.delete();
    lb_q = 1'b0;
    rv_cnt = 0;
    tdi_bad = 0;
  endtask

  task automatic start_cmd(input logic [1:0] op, input logic [4:0] len, input logic [31:0] data,
                           input bit hold, output bit to);
    int k = 0;
    to = 1'b0;
    while (!cmd_ready && k < 200) begin
      @(posedge tck); #1;
      k++;
    end
    if (!cmd_ready) begin
      to = 1'b1;
      return;
    end
    cmd_op = op; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
    @(posedge tck); #1;
    if (!hold) cmd_valid = 1'b0;
    clr();
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge tck); #1;
      cyc++;
    end while (!cmd_ready && cyc < 100);
  endtask

  task automatic test_reset();
    int cyc;
    #1 reset = 1'b0;
    repeat (3) @(posedge tck);
    #1;
    checks++;
    if ({tms, tdi, cmd_ready, busy, rsp_valid, rsp_data} !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL reset_values: got tms=%b tdi=%b rdy=%b busy=%b rv=%b rsp=%h, want 1 0 0 1 0 0",
               tms, tdi, cmd_ready, busy, rsp_valid, rsp_data);
    end
    reset = 1'b1;
    clr();
    wait_done(cyc);
    build_exp(2'b00, 0);
    checks++;
    if (cyc != RST_ONES + 1) begin
      errors++; $display("FAIL init_ready_rise: got %0d cycles, want %0d", cyc, RST_ONES + 1);
    end
    checks++;
    if (tms_q != exp_tms) begin
      errors++; $display("FAIL init_tms_seq: got %b (%0d), want %b (%0d)",
                         pack64(tms_q), tms_q.size(), pack64(exp_tms), exp_tms.size());
    end
    checks++;
    if (tap != 1 || tms !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL init_idle: got tap=%0d tms=%b rv=%b busy=%b, want 1 0 0 0",
                         tap, tms, rsp_valid, busy);
    end
  endtask

  task automatic test_dr_loopback();
    int cyc; bit to;
    tdo_mode = 1;
    start_cmd(2'b10, 5'd8, 32'hA5, 1'b0, to);
    wait_done(cyc);
    build_exp(2'b10, 8);
    checks++;
    if (to || cyc != 13) begin
      errors++; $display("FAIL dr8_latency: got %0d cycles (to=%0b), want 13", cyc, to);
    end
    checks++;
    if (tms_q != exp_tms) begin
      errors++; $display("FAIL dr8_tms_seq: got %b, want %b", pack64(tms_q), pack64(exp_tms));
    end
    checks++;
    if (sh_tdi.size() != 8 || pack64(sh_tdi) !== 64'hA5 || tdi_bad != 0) begin
      errors++; $display("FAIL dr8_tdi: got %h (%0d bits, %0d stray), want a5 (8 bits)",
                         pack64(sh_tdi), sh_tdi.size(), tdi_bad);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000004A || tap != 1) begin
      errors++; $display("FAIL dr8_rsp: got rv=%b rsp=%h tap=%0d, want 1 0000004a 1", rsp_valid, rsp_data, tap);
    end
    @(posedge tck); #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'h0000004A) begin
      errors++; $display("FAIL dr8_pulse_width: got rv=%b rsp=%h, want 0 0000004a", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_ir32();
    int cyc; bit to;
    tdo_mode = 2;
    start_cmd(2'b01, 5'd0, 32'hFFFF_FFFF, 1'b0, to);
    wait_done(cyc);
    build_exp(2'b01, 32);
    checks++;
    if (to || cyc != 38 || tms_q != exp_tms) begin
      errors++; $display("FAIL ir32_seq: got %0d cycles tms=%b, want 38 tms=%b", cyc, pack64(tms_q), pack64(exp_tms));
    end
    checks++;
    if (sh_tdi.size() != 32 || pack64(sh_tdi) !== 64'hFFFF_FFFF) begin
      errors++; $display("FAIL ir32_tdi: got %h (%0d bits), want ffffffff (32 bits)", pack64(sh_tdi), sh_tdi.size());
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd0 || tap != 1) begin
      errors++; $display("FAIL ir32_rsp: got rv=%b rsp=%h tap=%0d, want 1 00000000 1", rsp_valid, rsp_data, tap);
    end
  endtask

  task automatic test_back_to_back();
    int cyc; bit to;
    logic [31:0] d1, d2, exp_r;
    tdo_mode = 0;
    d1 = $urandom; d2 = $urandom;
    start_cmd(2'b01, 5'd4, d1, 1'b1, to);
    cmd_op = 2'b10; cmd_len = 5'd1; cmd_data = d2;
    wait_done(cyc);
    build_exp(2'b01, 4);
    exp_r = 32'(pack64(sh_tdo));
    checks++;
    if (to || cyc != 10 || tms_q != exp_tms || pack64(sh_tdi) !== 64'(d1 & 32'hF)) begin
      errors++; $display("FAIL b2b_ir: got %0d cycles tms=%b tdi=%h, want 10 tms=%b tdi=%h",
                         cyc, pack64(tms_q), pack64(sh_tdi), pack64(exp_tms), d1 & 32'hF);
    end
    checks++;
    if (rsp_valid !== 1'b1 || sh_tdo.size() != 4 || rsp_data !== exp_r) begin
      errors++; $display("FAIL b2b_ir_rsp: got rv=%b rsp=%h, want 1 %h", rsp_valid, rsp_data, exp_r);
    end
    @(posedge tck); #1;
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || tms !== 1'b1) begin
      errors++; $display("FAIL b2b_accept: got rdy=%b rv=%b tms=%b, want 0 0 1", cmd_ready, rsp_valid, tms);
    end
    clr();
    wait_done(cyc);
    build_exp(2'b10, 1);
    exp_r = 32'(pack64(sh_tdo));
    checks++;
    if (cyc != 6 || tms_q != exp_tms || sh_tdi.size() != 1 || pack64(sh_tdi) !== 64'(d2[0])) begin
      errors++; $display("FAIL b2b_dr: got %0d cycles tms=%b tdi=%h, want 6 tms=%b tdi=%0b",
                         cyc, pack64(tms_q), pack64(sh_tdi), pack64(exp_tms), d2[0]);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== exp_r || tap != 1) begin
      errors++; $display("FAIL b2b_dr_rsp: got rv=%b rsp=%h tap=%0d, want 1 %h 1", rsp_valid, rsp_data, tap, exp_r);
    end
  endtask

  task automatic test_abort_reset();
    int cyc; bit to;
    logic [31:0] d;
    tdo_mode = 0;
    d = $urandom;
    start_cmd(2'b10, 5'd16, d, 1'b0, to);
    repeat (6) @(posedge tck);
    #1;
    checks++;
    if (to || tms !== 1'b0 || tdi !== d[3] || tap != 4) begin
      errors++; $display("FAIL abort_in_shift3: got tms=%b tdi=%b tap=%0d, want 0 %b 4", tms, tdi, tap, d[3]);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({tms, tdi, cmd_ready, busy, rsp_valid, rsp_data} !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0}) begin
      errors++; $display("FAIL abort_reset_values: got tms=%b tdi=%b rdy=%b busy=%b rv=%b rsp=%h, want 1 0 0 1 0 0",
                         tms, tdi, cmd_ready, busy, rsp_valid, rsp_data);
    end
    repeat (2) @(posedge tck);
    #1 reset = 1'b1;
    clr();
    wait_done(cyc);
    build_exp(2'b00, 0);
    checks++;
    if (cyc != RST_ONES + 1 || tms_q != exp_tms || tap != 1) begin
      errors++; $display("FAIL abort_reinit: got %0d cycles tms=%b tap=%0d, want %0d tms=%b tap=1",
                         cyc, pack64(tms_q), tap, RST_ONES + 1, pack64(exp_tms));
    end
    checks++;
    if (rv_cnt != 0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL abort_no_rsp: got %0d pulses rv=%b, want 0 0", rv_cnt, rsp_valid);
    end
  endtask

  task automatic test_busy_ignore();
    int cyc; bit to;
    logic [31:0] prev;
    prev = rsp_data;
    start_cmd(2'b00, 5'd9, 32'h1234_5678, 1'b0, to);
    @(posedge tck); #1;
    cmd_op = 2'b10; cmd_len = 5'd7; cmd_valid = 1'b1;
    @(posedge tck); #1;
    cmd_valid = 1'b0;
    wait_done(cyc);
    build_exp(2'b00, 0);
    checks++;
    if (to || cyc + 2 != RST_ONES + 1 || tms_q != exp_tms || rv_cnt != 0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL busy_tapreset: got %0d cycles tms=%b pulses=%0d rv=%b, want %0d tms=%b 0 0",
                         cyc + 2, pack64(tms_q), rv_cnt, rsp_valid, RST_ONES + 1, pack64(exp_tms));
    end
    repeat (2) @(posedge tck);
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || tms !== 1'b0 || tdi !== 1'b0 || tap != 1) begin
      errors++; $display("FAIL busy_pulse_ignored: got rdy=%b tms=%b tdi=%b tap=%0d, want 1 0 0 1",
                         cmd_ready, tms, tdi, tap);
    end
    start_cmd(2'b11, 5'd3, 32'hFFFF_FFFF, 1'b0, to);
    wait_done(cyc);
    build_exp(2'b11, 3);
    checks++;
    if (to || cyc != 3 || tms_q != exp_tms || tdi_bad != 0 || tap != 1) begin
      errors++; $display("FAIL wait3_seq: got %0d cycles tms=%b stray_tdi=%0d, want 3 tms=%b 0",
                         cyc, pack64(tms_q), tdi_bad, pack64(exp_tms));
    end
    checks++;
    if (rsp_valid !== 1'b0 || rv_cnt != 0 || rsp_data !== prev) begin
      errors++; $display("FAIL wait3_rsp: got rv=%b rsp=%h, want 0 %h", rsp_valid, rsp_data, prev);
    end
  endtask

  task automatic test_random();
    int cyc, n; bit to; bit is_sh;
    logic [1:0] op; logic [4:0] len; logic [31:0] d, prev, exp_r;
    for (int it = 0; it < 14; it++) begin
      op = 2'($urandom_range(0, 3));
      len = 5'($urandom);
      d = $urandom;
      tdo_mode = $urandom_range(0, 2);
      n = n_of(len);
      is_sh = (op == 2'b01 || op == 2'b10);
      prev = rsp_data;
      start_cmd(op, len, d, 1'b0, to);
      wait_done(cyc);
      build_exp(op, n);
      exp_r = is_sh ? 32'(pack64(sh_tdo)) : prev;
      checks++;
      if (to || cyc != exp_tms.size() || tms_q != exp_tms || tap != 1) begin
        errors++; $display("FAIL rnd%0d_seq op=%0d n=%0d: got %0d cycles tms=%b tap=%0d, want %0d tms=%b tap=1",
                           it, op, n, cyc, pack64(tms_q), tap, exp_tms.size(), pack64(exp_tms));
      end
      checks++;
      if (sh_tdi.size() != (is_sh ? n : 0) || pack64(sh_tdi) !== (is_sh ? 64'(d & low_mask(n)) : 64'd0)
          || tdi_bad != 0) begin
        errors++; $display("FAIL rnd%0d_tdi op=%0d n=%0d: got %h (%0d bits, %0d stray), want %h",
                           it, op, n, pack64(sh_tdi), sh_tdi.size(), tdi_bad, d & low_mask(n));
      end
      checks++;
      if (rsp_valid !== is_sh || rv_cnt != 0 || rsp_data !== exp_r) begin
        errors++; $display("FAIL rnd%0d_rsp op=%0d n=%0d: got rv=%b rsp=%h, want %b %h",
                           it, op, n, rsp_valid, rsp_data, is_sh, exp_r);
      end
      @(posedge tck); #1;
      checks++;
      if (rsp_valid !== 1'b0 || rsp_data !== exp_r) begin
        errors++; $display("FAIL rnd%0d_hold: got rv=%b rsp=%h, want 0 %h", it, rsp_valid, rsp_data, exp_r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_dr_loopback();
    test_ir32();
    test_back_to_back();
    test_abort_reset();
    test_busy_ignore();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
